// File: rtl/shift_register_scheduler.sv
// Round-robin scheduler that loads one of two requesters' words into an external shift
// register and shifts it SHIFT_WIDTH times. Define SHIFT_SCHED_GAP_EN to add idle gap cycles.
module shift_register_scheduler #(
  parameter int   SHIFT_WIDTH = 8,
  parameter logic FILL_BIT    = 1'b0,
  parameter int   GAP_CYCLES  = 2
) (
  input  logic                   clock,
  input  logic                   sclr,
  input  logic                   req0_valid,
  input  logic [SHIFT_WIDTH-1:0] req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [SHIFT_WIDTH-1:0] req1_data,
  output logic                   req1_ready,
  output logic                   sr_load,
  output logic                   sr_enable,
  output logic [SHIFT_WIDTH-1:0] sr_data,
  output logic                   sr_shiftin,
  output logic                   busy,
  output logic                   grant_id,
  output logic                   frame_done
);

`ifdef SHIFT_SCHED_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  // With the gap feature off the GAP state is simply unreachable.
  localparam int GAP_N  = GAP_EN ? GAP_CYCLES : 0;
  localparam int CNT_W  = $clog2(SHIFT_WIDTH) + 1;
  localparam int GAP_CW = $clog2(GAP_N + 1) + 1;

  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SHIFT_WIDTH - 1);
  localparam logic [GAP_CW-1:0] LAST_GAP = GAP_CW'(GAP_N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GAP_CW-1:0]      gap_q, gap_d;
  logic [SHIFT_WIDTH-1:0] data_q, data_d;
  logic                   grant_q, grant_d;
  logic                   last_q, last_d;
  logic                   done_q, done_d;
  logic                   hs0, hs1;

  // On a tie the requester that did not own the previous frame wins.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!sclr && state_q == S_IDLE) begin
      req0_ready = req0_valid & (~req1_valid | last_q);
      req1_ready = req1_valid & (~req0_valid | ~last_q);
    end
  end

  assign hs0 = req0_valid & req0_ready;
  assign hs1 = req1_valid & req1_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    data_d  = data_q;
    grant_d = grant_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hs0 || hs1) begin
          data_d  = hs1 ? req1_data : req0_data;
          grant_d = hs1;
          last_d  = hs1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == LAST_CNT) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          gap_d   = '0;
          state_d = (GAP_N > 0) ? S_GAP : S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == LAST_GAP) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset aborts any frame in flight; the captured word is discarded.
  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign sr_load    = (state_q == S_LOAD);
  assign sr_enable  = (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign sr_data    = data_q;
  assign sr_shiftin = FILL_BIT;
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = grant_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_shift_register_scheduler.sv
// Directed bench for shift_register_scheduler: vector table plus hand-written sequences,
// with a SHIFT_WIDTH=1 instance for the minimum-length frame.
module tb_shift_register_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       sclr, v0, v1, r0, r1, ld, en, sin, busy, gid, done;
  logic [7:0] d0, d1, sd;

  logic       sclr1, a0v, a1v, a0r, a1r, ald, aen, asin, abusy, agid, adone;
  logic [0:0] ad0, ad1, asd;

  shift_register_scheduler #(.SHIFT_WIDTH(8), .FILL_BIT(1'b0), .GAP_CYCLES(2)) u_dut (
    .clock(clk), .sclr(sclr),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .sr_load(ld), .sr_enable(en), .sr_data(sd), .sr_shiftin(sin),
    .busy(busy), .grant_id(gid), .frame_done(done)
  );

  shift_register_scheduler #(.SHIFT_WIDTH(1), .FILL_BIT(1'b0), .GAP_CYCLES(2)) u_dut1 (
    .clock(clk), .sclr(sclr1),
    .req0_valid(a0v), .req0_data(ad0), .req0_ready(a0r),
    .req1_valid(a1v), .req1_data(ad1), .req1_ready(a1r),
    .sr_load(ald), .sr_enable(aen), .sr_data(asd), .sr_shiftin(asin),
    .busy(abusy), .grant_id(agid), .frame_done(adone)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected = {r0, r1, sr_load, sr_enable, busy, grant_id, frame_done, sr_shiftin, sr_data}
  typedef struct {
    logic        sclr, v0, v1;
    logic [7:0]  d0, d1;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic s, input logic a, input logic b,
                              input logic er0, input logic er1, input logic eld,
                              input logic een, input logic ebs, input logic egid,
                              input logic edn, input logic [7:0] esd);
    vec_t v;
    v.sclr = s; v.v0 = a; v.v1 = b; v.d0 = 8'h3C; v.d1 = 8'hA5;
    v.exp  = {er0, er1, eld, een, ebs, egid, edn, 1'b0, esd};
    vecs.push_back(v);
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    #1;
    while (busy && n < 40) begin
      @(negedge clk); #1; n++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, nacc, lastc, seen;
    sclr = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
    sclr1 = 1'b1; a0v = 1'b0; a1v = 1'b0; ad0 = 1'b0; ad1 = 1'b1;

    // reset with both valids, release, abort in LOAD, then a req1-only frame
    for (int i = 0; i < 3; i++) add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 8'h00);
    add(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 8'h3C);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 8'h00);
    add(0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 8'hA5);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 8'hA5);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 8'hA5);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'hA5);

    @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      sclr = vecs[i].sclr; v0 = vecs[i].v0; v1 = vecs[i].v1;
      d0 = vecs[i].d0; d1 = vecs[i].d1;
      #1;
      chk($sformatf("vec%0d", i), {16'd0, r0, r1, ld, en, busy, gid, done, sin, sd},
          {16'd0, vecs[i].exp});
    end

    // both requesters held for four frames
    cyc = 0; nacc = 0; lastc = 0;
    @(negedge clk);
    v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22;
    while (nacc < 4 && cyc < 60) begin
      #1;
      if (r0 || r1) begin
        chk($sformatf("t3_grant%0d", nacc), {30'd0, r0, r1}, (nacc % 2 == 0) ? 32'd2 : 32'd1);
        if (nacc > 0) chk($sformatf("t3_period%0d", nacc), cyc - lastc, 32'd10);
        lastc = cyc;
        nacc++;
      end
      @(negedge clk);
      cyc++;
    end
    v0 = 1'b0; v1 = 1'b0;
    chk("t3_accepts", nacc, 32'd4);
    #1;
    chk("t3_gid_data", {23'd0, gid, sd}, {23'd0, 1'b1, 8'h22});
    wait_idle("t3_idle");

    // reset in the fourth SHIFT cycle of a req0 frame
    @(negedge clk);
    v0 = 1'b1; d0 = 8'h5A;
    #1;
    chk("t4_r0", {31'd0, r0}, 32'd1);
    @(negedge clk);
    v0 = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    sclr = 1'b1;
    #1;
    chk("t4_shift_en", {30'd0, en, busy}, 32'd3);
    @(negedge clk);
    sclr = 1'b0;
    #1;
    chk("t4_after_rst", {29'd0, busy, en, done}, 32'd0);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (done) seen++;
    end
    chk("t4_no_done", seen, 32'd0);
    v0 = 1'b1; v1 = 1'b1;
    #1;
    chk("t4_tie_last", {30'd0, r0, r1}, 32'd2);

    // req0 pulse while busy must be ignored
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      v1 = 1'b0;
      v0 = (k == 3);
      #1;
      if (k == 1)  chk("t5_gid", {31'd0, gid}, 32'd0);
      if (k == 3)  chk("t5_no_ready", {30'd0, r0, r1}, 32'd0);
      if (k == 10) chk("t5_done", {31'd0, done}, 32'd1);
      if (k == 12) chk("t5_stays_idle", {30'd0, busy, en}, 32'd0);
    end
    chk("fill_bits", {30'd0, sin, asin}, 32'd0);

    // SHIFT_WIDTH=1, back-to-back ties
    @(negedge clk);
    sclr1 = 1'b0; a0v = 1'b1; a1v = 1'b1;
    for (int i = 0; i < 9; i++) begin
      logic [7:0] e;
      int k, p;
      logic g;
      k = i / 3; p = i % 3;
      #1;
      if (p == 0) begin
        g = (i == 0) ? 1'b0 : logic'((k - 1) % 2);
        e = {(k % 2 == 0), (k % 2 == 1), 1'b0, 1'b0, (i > 0), g, g, 1'b0};
      end else begin
        g = logic'(k % 2);
        e = {1'b0, 1'b0, (p == 1), 1'b1, 1'b0, g, g, 1'b1};
      end
      chk($sformatf("t6_cyc%0d", i), {24'd0, a0r, a1r, ald, aen, adone, agid, asd, abusy},
          {24'd0, e});
      @(negedge clk);
    end
    a0v = 1'b0; a1v = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
